// File: rtl/alu_shift_pkg.sv
// Shared types for the sequential ALU shifter: shift mode encoding and FSM states.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit step of the working register for one shift mode.
// The rotate path is only built when ALU_SHIFT_ROTATE_EN is defined; otherwise ROL steps as SLL.
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] work_i,
  input  shift_mode_t        mode_i,
  output logic [2*WIDTH-1:0] work_o
);

  always_comb begin
    work_o = work_i;
    unique case (mode_i)
      SLL: work_o = {work_i[2*WIDTH-2:0], 1'b0};
      SRL: work_o = {1'b0, work_i[2*WIDTH-1:1]};
      SRA: work_o = {work_i[2*WIDTH-1], work_i[2*WIDTH-1:1]};
`ifdef ALU_SHIFT_ROTATE_EN
      // rotation is confined to the low half; the high half stays zero
      ROL: work_o = {{WIDTH{1'b0}}, work_i[WIDTH-2:0], work_i[WIDTH-1]};
`else
      ROL: work_o = {work_i[2*WIDTH-2:0], 1'b0};
`endif
      default: work_o = work_i;
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-mode sequential shifter, one bit per clock, valid/ready on both sides.
// Optional rotate mode enabled by macro ALU_SHIFT_ROTATE_EN.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 Z
);

  localparam int CW = $clog2(2*WIDTH+1);

  shift_state_t        state_q, state_d;
  shift_mode_t         mode_q, mode_d;
  logic [2*WIDTH-1:0]  work_q, work_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  shift_mode_t         req_mode;
  logic [CW-1:0]       eff_cnt;
  logic [2*WIDTH-1:0]  load_val;
  logic [2*WIDTH-1:0]  step_val;
  logic [31:0]         b_ext;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .work_i (work_q),
    .mode_i (mode_q),
    .work_o (step_val)
  );

  // Request decode: mode, effective count and register load value
  always_comb begin
    b_ext    = 32'(B);
    req_mode = shift_mode_t'(mode);
`ifndef ALU_SHIFT_ROTATE_EN
    if (req_mode == ROL) req_mode = SLL;
`endif
    if (b_ext >= 32'(2*WIDTH)) eff_cnt = CW'(2*WIDTH);
    else                       eff_cnt = CW'(b_ext);
`ifdef ALU_SHIFT_ROTATE_EN
    if (req_mode == ROL) eff_cnt = CW'(b_ext % 32'(WIDTH));
`endif
    if (req_mode == SRA) load_val = {{WIDTH{A[WIDTH-1]}}, A};
    else                 load_val = {{WIDTH{1'b0}}, A};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= SLL;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = req_mode;
          work_d  = load_val;
          cnt_d   = eff_cnt;
          state_d = (eff_cnt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_d = step_val;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    Y         = work_q;
    Z         = ~|work_q;
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq (WIDTH=4): directed cases, bounds, backpressure, reset abort, random.
module tb_alu_shift_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] Y;
  logic           Z;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2*W-1:0] y;
    int             lat;
  } exp_t;

  exp_t exp_q[$];

  alu_shift_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_count(input logic [W-1:0] b, input logic [1:0] m);
`ifdef ALU_SHIFT_ROTATE_EN
    if (m == 2'b11) return int'(b) % W;
`endif
    return (int'(b) >= 2*W) ? 2*W : int'(b);
  endfunction

  function automatic logic [2*W-1:0] model_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] m);
    logic [2*W-1:0] zx;
    logic [2*W-1:0] sx;
    logic [W-1:0]   r;
    int k;
    zx = {{W{1'b0}}, a};
    sx = {{W{a[W-1]}}, a};
    k  = eff_count(b, m);
    case (m)
      2'b01: return zx >> k;
      2'b10: return $unsigned($signed(sx) >>> k);
`ifdef ALU_SHIFT_ROTATE_EN
      2'b11: begin
        r = (k == 0) ? a : ((a << k) | (a >> (W - k)));
        return {{W{1'b0}}, r};
      end
`endif
      default: return zx << k;
    endcase
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                      input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_req", 32'(in_ready), 32'd1);
    A = a; B = b; mode = m; in_valid = 1'b1;
    if (push) exp_q.push_back('{model_y(a, b, m), eff_count(b, m) + 1});
    @(posedge clk);
    #1;
    // scramble inputs after accept: they must be ignored
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); mode = 2'($urandom);
  endtask

  task automatic collect(input int hold);
    int   lat = 1;
    exp_t e;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("Y", 32'(Y), 32'(e.y));
    chk("Z", 32'(Z), 32'(e.y == '0));
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_Y_stable", 32'(Y), 32'(e.y));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; mode = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_Y", 32'(Y), 32'd0);
    chk("rst_Z", 32'(Z), 32'd1);
    rst = 1'b0;

    // directed cases
    send(4'b1011, 4'd3, 2'b00, 1'b1); collect(0);  // SLL -> 58, lat 4
    send(4'b1000, 4'd2, 2'b10, 1'b1); collect(0);  // SRA -> FE, lat 3
    send(4'b1000, 4'd2, 2'b01, 1'b1); collect(0);  // SRL -> 02
    send(4'hF,    4'd15, 2'b00, 1'b1); collect(0); // SLL bound -> 00, lat 9
    send(4'hF,    4'd15, 2'b10, 1'b1); collect(0); // SRA bound -> FF, lat 9
    send(4'hF,    4'd15, 2'b01, 1'b1); collect(0); // SRL bound -> 00
    send(4'b1001, 4'd5, 2'b11, 1'b1); collect(0);  // ROL: 03/lat 2 or SLL: 20/lat 6
    send(4'b0110, 4'd0, 2'b00, 1'b1); collect(5);  // zero count + backpressure
    send(4'b1010, 4'd0, 2'b10, 1'b1); collect(0);  // zero count SRA: sign-extended
    send(4'b1100, 4'd4, 2'b11, 1'b1); collect(2);

    // reset while shifting: result must be dropped
    send(4'hF, 4'd15, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_Y", 32'(Y), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    chk("abort_idle_in_ready", 32'(in_ready), 32'd1);

    // random traffic with random backpressure
    for (int i = 0; i < 25; i++) begin
      send(W'($urandom), W'($urandom), 2'($urandom), 1'b1);
      collect(int'($urandom_range(0, 2)));
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
